pri_req_sched_v: RTL



---
 rtl/pri_req_sched_v_if.sv | 23 ++
 rtl/pri_req_sched_v.sv | 119 +++++++++++
 2 files changed

// File: rtl/pri_req_sched_v_if.sv
// Request/grant bundle between the request lines, the scheduler and the code consumer.
interface pri_req_sched_v_if #(
    parameter int N_REQ  = 4,
    parameter int CODE_W = 2
);
    logic [N_REQ-1:0]  req;
    logic              ready;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic [N_REQ-1:0]  pending;
    logic              ovf_clr;
    logic [N_REQ-1:0]  ovf;

    modport master (
        input  req, ready, ovf_clr,
        output code, valid, pending, ovf
    );

    modport slave (
        output req, ready, ovf_clr,
        input  code, valid, pending, ovf
    );
endinterface

// File: rtl/pri_req_sched_v.sv
// Sticky request capture + fixed-priority (line 0 first) grant of one code at a time; PRI_SCHED_OVF_EN adds overflow flags.
// Latency: request -> valid in 2 edges; code held until ready, next code 1 edge after accept (GAP_CYC+1 with a gap).
module pri_req_sched_v #(
    parameter int N_REQ   = 4,
    parameter int CODE_W  = 2,
    parameter int GAP_CYC = 0
) (
    input logic              i_clk,
    input logic              i_rst_n,
    pri_req_sched_v_if.master bus
);
    typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

    localparam logic [3:0] GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    state_t            state_q;
    logic [N_REQ-1:0]  pending_q;
    logic [CODE_W-1:0] code_q;
    logic              valid_q;
    logic [3:0]        gap_cnt_q;

    logic              acc;
    logic [N_REQ-1:0]  clr;
    logic [N_REQ-1:0]  pend_nxt;

    // Lowest set index wins; scanning downward leaves the lowest hit last.
    function automatic logic [CODE_W-1:0] pick(input logic [N_REQ-1:0] v);
        logic [CODE_W-1:0] r;
        r = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (v[k]) r = CODE_W'(k);
        end
        return r;
    endfunction

    always_comb begin
        acc      = valid_q & bus.ready;
        clr      = acc ? (N_REQ'(1) << code_q) : '0;
        pend_nxt = (pending_q & ~clr) | bus.req;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            gap_cnt_q <= '0;
        end else begin
            pending_q <= pend_nxt;
            unique case (state_q)
                IDLE: begin
                    // Registered pending only: gives the two-edge request-to-valid latency.
                    if (|pending_q) begin
                        state_q <= OFFER;
                        valid_q <= 1'b1;
                        code_q  <= pick(pending_q);
                    end
                end
                OFFER: begin
                    if (acc) begin
                        if (GAP_CYC > 0) begin
                            state_q   <= GAP;
                            gap_cnt_q <= GAP_LOAD;
                            valid_q   <= 1'b0;
                        end else if (|pend_nxt) begin
                            code_q <= pick(pend_nxt);
                        end else begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == 4'd0) begin
                        if (|pend_nxt) begin
                            state_q <= OFFER;
                            valid_q <= 1'b1;
                            code_q  <= pick(pend_nxt);
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.code    = code_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pending_q;

`ifdef PRI_SCHED_OVF_EN
    logic [N_REQ-1:0] ovf_q;

    // A repeat request on a still-pending line is a lost event unless that line is being granted now.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ovf_q <= '0;
        end else if (bus.ovf_clr) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_q | (bus.req & pending_q & ~clr);
        end
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = bus.ovf_clr;
    assign bus.ovf        = '0;
`endif
endmodule
